hsv_track_ctrl: RTL and testbench

Sequences a raster RGB pixel stream through the free-running hsvConverter datapath. Realigns the converter outputs with pixel coordinates and valid flags, and classifies each pixel against a programmable HSV window. Accumulates a per-frame bounding box and hit count of the matching pixels. Sits between the camera pixel source and the paddle-position logic, and publishes one result per completed frame.

---
 rtl/hsv_track_pkg.sv | 34 +++
 rtl/hsv_window_cmp.sv | 32 +++
 rtl/hsv_track_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_hsv_track_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_track_pkg.sv
// Shared types for the HSV colour tracker: FSM states,
// default geometry and the HSV window bundle.
package hsv_track_pkg;

   localparam int DEF_XW       = 10;
   localparam int DEF_YW       = 10;
   localparam int DEF_CONV_LAT = 2;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      FLUSH,
      REPORT
   } state_t;

   typedef struct packed {
      logic [7:0] h_lo;
      logic [7:0] h_hi;
      logic [7:0] s_lo;
      logic [7:0] s_hi;
      logic [7:0] v_lo;
      logic [7:0] v_hi;
   } hsv_win_t;

   // An inverted window (lo > hi) can never be satisfied.
   function automatic logic in_rng(
      input logic [7:0] v,
      input logic [7:0] lo,
      input logic [7:0] hi
   );
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/hsv_window_cmp.sv
// Registered three-channel inclusive HSV range check.
// Output is forced low for bubble slots.
module hsv_window_cmp
   import hsv_track_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       vld,
   input  logic [7:0] h,
   input  logic [7:0] s,
   input  logic [7:0] v,
   input  logic [7:0] h_lo,
   input  logic [7:0] h_hi,
   input  logic [7:0] s_lo,
   input  logic [7:0] s_hi,
   input  logic [7:0] v_lo,
   input  logic [7:0] v_hi,
   output logic       hit
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         hit <= 1'b0;
      end else begin
         hit <= vld
              & in_rng(h, h_lo, h_hi)
              & in_rng(s, s_lo, s_hi)
              & in_rng(v, v_lo, v_hi);
      end
   end

endmodule

// File: rtl/hsv_track_ctrl.sv
// Feeds raster RGB through the HSV converter, classifies each
// pixel against a window and reports a per-frame bounding box.
module hsv_track_ctrl
   import hsv_track_pkg::*;
#(
   parameter int XW        = DEF_XW,
   parameter int YW        = DEF_YW,
   parameter int CONV_LAT  = DEF_CONV_LAT,
   parameter int MIN_COUNT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_valid,
   input  logic [7:0]       pix_r,
   input  logic [7:0]       pix_g,
   input  logic [7:0]       pix_b,
   input  logic             pix_sof,
   input  logic             pix_eol,
   input  logic             pix_eof,
   input  logic [7:0]       thr_h_lo,
   input  logic [7:0]       thr_h_hi,
   input  logic [7:0]       thr_s_lo,
   input  logic [7:0]       thr_s_hi,
   input  logic [7:0]       thr_v_lo,
   input  logic [7:0]       thr_v_hi,
   output logic [7:0]       cv_r,
   output logic [7:0]       cv_g,
   output logic [7:0]       cv_b,
   input  logic [7:0]       cv_h,
   input  logic [7:0]       cv_s,
   input  logic [7:0]       cv_v,
   output logic             mask_valid,
   output logic             mask_bit,
   output logic [XW-1:0]    mask_x,
   output logic [YW-1:0]    mask_y,
   output logic             res_valid,
   output logic             res_found,
   output logic [XW+YW-1:0] res_count,
   output logic [XW-1:0]    res_xmin,
   output logic [XW-1:0]    res_xmax,
   output logic [YW-1:0]    res_ymin,
   output logic [YW-1:0]    res_ymax,
   output logic [XW-1:0]    res_xc
);

   localparam int CW = XW + YW;
   localparam logic [3:0] DRAIN = 4'(CONV_LAT + 2);
   localparam logic [CW-1:0] MIN_C = CW'(MIN_COUNT);

   logic sof_v, eof_v;
   assign sof_v = pix_valid & pix_sof;
   assign eof_v = pix_valid & pix_eof;

   logic [XW-1:0] x_q, cur_x;
   logic [YW-1:0] y_q, cur_y;
   logic          in_tag, cur_tag;

   assign cur_x   = sof_v ? '0 : x_q;
   assign cur_y   = sof_v ? '0 : y_q;
   assign cur_tag = sof_v ? ~in_tag : in_tag;

   always_ff @(posedge clk) begin
      if (!rst) begin
         x_q    <= '0;
         y_q    <= '0;
         in_tag <= 1'b0;
      end else if (pix_valid) begin
         in_tag <= cur_tag;
         if (pix_eol) begin
            x_q <= '0;
            y_q <= cur_y + YW'(1);
         end else begin
            x_q <= cur_x + XW'(1);
            y_q <= cur_y;
         end
      end
   end

   // One shadow window per frame tag, so pixels still draining
   // from the previous frame keep the window they started with.
   hsv_win_t thr, win;
   hsv_win_t shd [2];

   assign thr = {thr_h_lo, thr_h_hi, thr_s_lo,
                 thr_s_hi, thr_v_lo, thr_v_hi};

   always_ff @(posedge clk) begin
      if (!rst) begin
         shd[0] <= '0;
         shd[1] <= '0;
      end else if (sof_v) begin
         shd[~in_tag] <= thr;
      end
   end

   logic [CONV_LAT:0] dv, dt;
   logic [XW-1:0]     dx [0:CONV_LAT];
   logic [YW-1:0]     dy [0:CONV_LAT];

   always_ff @(posedge clk) begin
      if (!rst) begin
         cv_r <= '0;
         cv_g <= '0;
         cv_b <= '0;
         dv   <= '0;
         dt   <= '0;
         for (int i = 0; i <= CONV_LAT; i++) begin
            dx[i] <= '0;
            dy[i] <= '0;
         end
      end else begin
         if (pix_valid) begin
            cv_r <= pix_r;
            cv_g <= pix_g;
            cv_b <= pix_b;
         end
         dv    <= {dv[CONV_LAT-1:0], pix_valid};
         dt    <= {dt[CONV_LAT-1:0], cur_tag};
         dx[0] <= cur_x;
         dy[0] <= cur_y;
         for (int i = 1; i <= CONV_LAT; i++) begin
            dx[i] <= dx[i-1];
            dy[i] <= dy[i-1];
         end
      end
   end

   assign win = shd[dt[CONV_LAT]];

   hsv_window_cmp u_cmp (
      .clk  (clk),
      .rst  (rst),
      .vld  (dv[CONV_LAT]),
      .h    (cv_h),
      .s    (cv_s),
      .v    (cv_v),
      .h_lo (win.h_lo),
      .h_hi (win.h_hi),
      .s_lo (win.s_lo),
      .s_hi (win.s_hi),
      .v_lo (win.v_lo),
      .v_hi (win.v_hi),
      .hit  (mask_bit)
   );

   logic mask_tag;

   always_ff @(posedge clk) begin
      if (!rst) begin
         mask_valid <= 1'b0;
         mask_x     <= '0;
         mask_y     <= '0;
         mask_tag   <= 1'b0;
      end else begin
         mask_valid <= dv[CONV_LAT];
         mask_x     <= dx[CONV_LAT];
         mask_y     <= dy[CONV_LAT];
         mask_tag   <= dt[CONV_LAT];
      end
   end

   state_t     state, state_nx;
   logic [3:0] drain, drain_nx;
   logic       pend, pend_nx;
   logic       pend_eof, pend_eof_nx;
   logic       acc_tag, acc_tag_nx;
   logic       acc_clr, rep;

   always_comb begin
      state_nx    = state;
      drain_nx    = drain;
      pend_nx     = pend;
      pend_eof_nx = pend_eof;
      acc_tag_nx  = acc_tag;
      acc_clr     = 1'b0;
      rep         = 1'b0;
      unique case (state)
         IDLE: begin
            if (sof_v) begin
               acc_clr    = 1'b1;
               acc_tag_nx = ~in_tag;
               drain_nx   = DRAIN;
               state_nx   = eof_v ? FLUSH : ACTIVE;
            end
         end
         ACTIVE: begin
            if (sof_v) begin
               acc_clr    = 1'b1;
               acc_tag_nx = ~in_tag;
            end
            if (eof_v) begin
               drain_nx = DRAIN;
               state_nx = FLUSH;
            end
         end
         FLUSH: begin
            // A new frame here is held pending until the report.
            if (sof_v)
               pend_nx = 1'b1;
            if (eof_v && (pend || sof_v))
               pend_eof_nx = 1'b1;
            if (drain == 4'd0) begin
               rep      = 1'b1;
               state_nx = REPORT;
               if (pend || sof_v) begin
                  acc_clr    = 1'b1;
                  acc_tag_nx = cur_tag;
               end
            end else begin
               drain_nx = drain - 4'd1;
            end
         end
         REPORT: begin
            pend_nx     = 1'b0;
            pend_eof_nx = 1'b0;
            drain_nx    = DRAIN;
            if (sof_v) begin
               acc_clr    = 1'b1;
               acc_tag_nx = ~in_tag;
            end
            if (pend_eof || ((pend || sof_v) && eof_v))
               state_nx = FLUSH;
            else if (pend || sof_v)
               state_nx = ACTIVE;
            else
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   logic          hit, hit_tag;
   logic [XW-1:0] xmin, xmax;
   logic [YW-1:0] ymin, ymax;
   logic [CW-1:0] cnt;

   assign hit_tag = acc_clr ? acc_tag_nx : acc_tag;
   assign hit = mask_valid & mask_bit
              & (mask_tag == hit_tag) & (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         drain    <= '0;
         pend     <= 1'b0;
         pend_eof <= 1'b0;
         acc_tag  <= 1'b0;
         xmin     <= '0;
         xmax     <= '0;
         ymin     <= '0;
         ymax     <= '0;
         cnt      <= '0;
      end else begin
         state    <= state_nx;
         drain    <= drain_nx;
         pend     <= pend_nx;
         pend_eof <= pend_eof_nx;
         acc_tag  <= acc_tag_nx;
         if (acc_clr) begin
            xmin <= hit ? mask_x : '1;
            xmax <= hit ? mask_x : '0;
            ymin <= hit ? mask_y : '1;
            ymax <= hit ? mask_y : '0;
            cnt  <= hit ? CW'(1) : '0;
         end else if (hit) begin
            if (mask_x < xmin) xmin <= mask_x;
            if (mask_x > xmax) xmax <= mask_x;
            if (mask_y < ymin) ymin <= mask_y;
            if (mask_y > ymax) ymax <= mask_y;
            if (cnt != '1) cnt <= cnt + CW'(1);
         end
      end
   end

   logic [XW:0] xsum;
   assign xsum = {1'b0, xmin} + {1'b0, xmax};

   always_ff @(posedge clk) begin
      if (!rst) begin
         res_valid <= 1'b0;
         res_found <= 1'b0;
         res_count <= '0;
         res_xmin  <= '0;
         res_xmax  <= '0;
         res_ymin  <= '0;
         res_ymax  <= '0;
         res_xc    <= '0;
      end else begin
         res_valid <= rep;
         if (rep) begin
            res_found <= (cnt >= MIN_C);
            res_count <= cnt;
            res_xmin  <= xmin;
            res_xmax  <= xmax;
            res_ymin  <= ymin;
            res_ymax  <= ymax;
            res_xc    <= xsum[XW:1];
         end
      end
   end

endmodule

// File: tb/tb_hsv_track_ctrl.sv
// Directed bench for hsv_track_ctrl with an identity
// two-stage converter model (h=r, s=g, v=b).
module tb_hsv_track_ctrl;

   localparam int L = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       pix_valid = 0, pix_sof = 0, pix_eol = 0, pix_eof = 0;
   logic [7:0] pix_r = 0, pix_g = 0, pix_b = 0;
   logic [7:0] thr_h_lo = 10, thr_h_hi = 20;
   logic [7:0] thr_s_lo = 0, thr_s_hi = 255;
   logic [7:0] thr_v_lo = 0, thr_v_hi = 255;
   logic [7:0] cv_r, cv_g, cv_b, cv_h, cv_s, cv_v;
   logic       mask_valid, mask_bit;
   logic [9:0] mask_x, mask_y;
   logic       res_valid, res_found;
   logic [19:0] res_count;
   logic [9:0] res_xmin, res_xmax, res_ymin, res_ymax, res_xc;

   hsv_track_ctrl #(
      .XW(10), .YW(10), .CONV_LAT(L), .MIN_COUNT(2)
   ) dut (
      .clk(clk), .rst(rst),
      .pix_valid(pix_valid),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
      .thr_h_lo(thr_h_lo), .thr_h_hi(thr_h_hi),
      .thr_s_lo(thr_s_lo), .thr_s_hi(thr_s_hi),
      .thr_v_lo(thr_v_lo), .thr_v_hi(thr_v_hi),
      .cv_r(cv_r), .cv_g(cv_g), .cv_b(cv_b),
      .cv_h(cv_h), .cv_s(cv_s), .cv_v(cv_v),
      .mask_valid(mask_valid), .mask_bit(mask_bit),
      .mask_x(mask_x), .mask_y(mask_y),
      .res_valid(res_valid), .res_found(res_found),
      .res_count(res_count),
      .res_xmin(res_xmin), .res_xmax(res_xmax),
      .res_ymin(res_ymin), .res_ymax(res_ymax),
      .res_xc(res_xc)
   );

   logic [23:0] cpipe [L];
   initial for (int i = 0; i < L; i++) cpipe[i] = '0;
   always @(posedge clk) begin
      cpipe[0] <= {cv_r, cv_g, cv_b};
      for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
   end
   assign {cv_h, cv_s, cv_v} = cpipe[L-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c; int x; int y; logic b;
   } mrec_t;
   typedef struct {
      int c; logic f; logic [19:0] n;
      logic [9:0] x0, x1, y0, y1, xc;
   } rrec_t;

   mrec_t mq[$];
   rrec_t rq[$];
   mrec_t mm;
   rrec_t rr;

   always @(negedge clk) begin
      if (mask_valid) begin
         mm.c = cyc; mm.x = int'(mask_x);
         mm.y = int'(mask_y); mm.b = mask_bit;
         mq.push_back(mm);
      end
      if (res_valid) begin
         rr.c = cyc; rr.f = res_found; rr.n = res_count;
         rr.x0 = res_xmin; rr.x1 = res_xmax;
         rr.y0 = res_ymin; rr.y1 = res_ymax; rr.xc = res_xc;
         rq.push_back(rr);
      end
   end

   int nvec = 0;
   int nerr = 0;

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pix(input logic [7:0] r, input logic s,
                      input logic e, input logic f, output int t);
      pix_valid = 1; pix_r = r; pix_g = 8'd50; pix_b = 8'd50;
      pix_sof = s; pix_eol = e; pix_eof = f;
      t = cyc;
      @(posedge clk);
      #1;
      pix_valid = 0; pix_sof = 0; pix_eol = 0; pix_eof = 0;
   endtask

   task automatic test_reset();
      int t;
      pix(8'd15, 1, 0, 0, t);
      pix(8'd15, 0, 0, 0, t);
      pix(8'd15, 0, 0, 0, t);
      rst = 0;
      idle(3);
      nvec++;
      if ({cv_r, cv_g, cv_b} !== 24'h0) begin
         nerr++;
         $display("FAIL reset_cv got=%h want=0", {cv_r, cv_g, cv_b});
      end
      nvec++;
      if ({mask_valid, mask_bit, mask_x, mask_y} !== 22'h0) begin
         nerr++;
         $display("FAIL reset_mask got=%h want=0",
                  {mask_valid, mask_bit, mask_x, mask_y});
      end
      nvec++;
      if ({res_valid, res_found, res_count, res_xmin, res_xmax,
           res_ymin, res_ymax, res_xc} !== 72'h0) begin
         nerr++;
         $display("FAIL reset_res got=%h want=0",
                  {res_valid, res_found, res_count, res_xmin,
                   res_xmax, res_ymin, res_ymax, res_xc});
      end
      rst = 1;
      mq.delete();
      rq.delete();
      pix(8'd15, 0, 0, 0, t);
      pix(8'd15, 0, 1, 1, t);
      idle(14);
      nvec++;
      if (rq.size() !== 0) begin
         nerr++;
         $display("FAIL reset_no_res got=%0d pulses want=0", rq.size());
      end
   endtask

   task automatic test_frame_4x2();
      int t, tm;
      tm = 0;
      mq.delete();
      rq.delete();
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++) begin
            pix((x == 2 && y == 1) ? 8'd15 : 8'd100,
                x == 0 && y == 0, x == 3, x == 3 && y == 1, t);
            if (x == 2 && y == 1) tm = t;
         end
      idle(12);
      nvec++;
      if (mq.size() !== 8) begin
         nerr++;
         $display("FAIL f4x2_nmask got=%0d want=8", mq.size());
      end
      for (int i = 0; i < mq.size() && i < 8; i++) begin
         nvec++;
         if (mq[i].x !== i % 4 || mq[i].y !== i / 4
             || mq[i].b !== (i == 6)) begin
            nerr++;
            $display("FAIL f4x2_mask%0d got=(%0d,%0d,%b) want=(%0d,%0d,%b)",
                     i, mq[i].x, mq[i].y, mq[i].b, i % 4, i / 4, i == 6);
         end
      end
      if (mq.size() > 6) begin
         nvec++;
         if (mq[6].c !== tm + 4) begin
            nerr++;
            $display("FAIL f4x2_lat got=%0d want=%0d", mq[6].c, tm + 4);
         end
      end
      nvec++;
      if (rq.size() !== 1) begin
         nerr++;
         $display("FAIL f4x2_nres got=%0d want=1", rq.size());
      end else begin
         nvec++;
         if ({rq[0].n, rq[0].x0, rq[0].x1, rq[0].y0, rq[0].y1,
              rq[0].xc, rq[0].f} !== {20'd1, 10'd2, 10'd2, 10'd1,
                                      10'd1, 10'd2, 1'b0}) begin
            nerr++;
            $display("FAIL f4x2_res got n=%0d bb=%0d,%0d,%0d,%0d xc=%0d f=%b want n=1 bb=2,2,1,1 xc=2 f=0",
                     rq[0].n, rq[0].x0, rq[0].x1, rq[0].y0, rq[0].y1,
                     rq[0].xc, rq[0].f);
         end
      end
   endtask

   task automatic test_min_count();
      int t;
      rq.delete();
      for (int x = 0; x < 10; x++)
         pix((x == 3 || x == 9) ? 8'd15 : 8'd100,
             x == 0, x == 9, x == 9, t);
      idle(12);
      nvec++;
      if (rq.size() !== 1) begin
         nerr++;
         $display("FAIL minc_nres got=%0d want=1", rq.size());
      end else begin
         nvec++;
         if ({rq[0].n, rq[0].x0, rq[0].x1, rq[0].y0, rq[0].y1,
              rq[0].xc, rq[0].f} !== {20'd2, 10'd3, 10'd9, 10'd0,
                                      10'd0, 10'd6, 1'b1}) begin
            nerr++;
            $display("FAIL minc_res got n=%0d bb=%0d,%0d,%0d,%0d xc=%0d f=%b want n=2 bb=3,9,0,0 xc=6 f=1",
                     rq[0].n, rq[0].x0, rq[0].x1, rq[0].y0, rq[0].y1,
                     rq[0].xc, rq[0].f);
         end
      end
   endtask

   task automatic test_abort();
      int t;
      rq.delete();
      for (int x = 0; x < 5; x++)
         pix(8'd15, x == 0, 0, 0, t);
      pix(8'd100, 1, 0, 0, t);
      pix(8'd100, 0, 1, 1, t);
      idle(12);
      nvec++;
      if (rq.size() !== 1) begin
         nerr++;
         $display("FAIL abort_nres got=%0d want=1", rq.size());
      end else begin
         nvec++;
         if ({rq[0].n, rq[0].x0, rq[0].x1, rq[0].y0, rq[0].y1,
              rq[0].xc, rq[0].f} !== {20'd0, 10'd1023, 10'd0,
                                      10'd1023, 10'd0, 10'd511,
                                      1'b0}) begin
            nerr++;
            $display("FAIL abort_res got n=%0d bb=%0d,%0d,%0d,%0d xc=%0d f=%b want n=0 bb=1023,0,1023,0 xc=511 f=0",
                     rq[0].n, rq[0].x0, rq[0].x1, rq[0].y0, rq[0].y1,
                     rq[0].xc, rq[0].f);
         end
      end
   endtask

   task automatic run_line(input logic [5:0] eb, input int gaps,
                           input logic chg, input logic [19:0] en,
                           input logic [9:0] ex0, input logic [9:0] ex1,
                           input string nm);
      int t;
      logic [7:0] vals [6];
      vals = '{8'd5, 8'd10, 8'd15, 8'd20, 8'd25, 8'd18};
      mq.delete();
      rq.delete();
      for (int x = 0; x < 6; x++) begin
         pix(vals[x], x == 0, x == 5, x == 5, t);
         if (chg && x == 0) thr_h_hi = 8'd12;
         if (gaps != 0 && x < 5) idle($urandom_range(0, 1));
      end
      idle(12);
      nvec++;
      if (mq.size() !== 6) begin
         nerr++;
         $display("FAIL %s_nmask got=%0d want=6", nm, mq.size());
      end
      for (int i = 0; i < mq.size() && i < 6; i++) begin
         nvec++;
         if (mq[i].x !== i || mq[i].b !== eb[i]) begin
            nerr++;
            $display("FAIL %s_mask%0d got=(x%0d,%b) want=(x%0d,%b)",
                     nm, i, mq[i].x, mq[i].b, i, eb[i]);
         end
      end
      nvec++;
      if (rq.size() !== 1) begin
         nerr++;
         $display("FAIL %s_nres got=%0d want=1", nm, rq.size());
      end else begin
         nvec++;
         if ({rq[0].n, rq[0].x0, rq[0].x1, rq[0].y0, rq[0].y1}
             !== {en, ex0, ex1, 10'd0, 10'd0}) begin
            nerr++;
            $display("FAIL %s_res got n=%0d bb=%0d,%0d,%0d,%0d want n=%0d bb=%0d,%0d,0,0",
                     nm, rq[0].n, rq[0].x0, rq[0].x1, rq[0].y0,
                     rq[0].y1, en, ex0, ex1);
         end
      end
   endtask

   task automatic test_shadow_bubbles();
      thr_h_hi = 8'd20;
      run_line(6'b101110, 0, 0, 20'd4, 10'd1, 10'd5, "ref");
      run_line(6'b101110, 1, 1, 20'd4, 10'd1, 10'd5, "bub");
      run_line(6'b000010, 0, 0, 20'd1, 10'd1, 10'd1, "next");
      thr_h_hi = 8'd20;
   endtask

   task automatic test_single();
      int t;
      mq.delete();
      rq.delete();
      pix(8'd15, 1, 1, 1, t);
      idle(12);
      nvec++;
      if (mq.size() !== 1) begin
         nerr++;
         $display("FAIL single_nmask got=%0d want=1", mq.size());
      end else begin
         nvec++;
         if (mq[0].c !== t + 4 || mq[0].b !== 1'b1) begin
            nerr++;
            $display("FAIL single_mask got=(c%0d,%b) want=(c%0d,1)",
                     mq[0].c, mq[0].b, t + 4);
         end
      end
      nvec++;
      if (rq.size() !== 1) begin
         nerr++;
         $display("FAIL single_nres got=%0d want=1", rq.size());
      end else begin
         nvec++;
         if (rq[0].c !== t + L + 4) begin
            nerr++;
            $display("FAIL single_lat got=%0d want=%0d",
                     rq[0].c, t + L + 4);
         end
         nvec++;
         if ({rq[0].n, rq[0].x0, rq[0].x1, rq[0].xc}
             !== {20'd1, 10'd0, 10'd0, 10'd0}) begin
            nerr++;
            $display("FAIL single_res got n=%0d x=%0d..%0d xc=%0d want n=1 x=0..0 xc=0",
                     rq[0].n, rq[0].x0, rq[0].x1, rq[0].xc);
         end
      end
   endtask

   initial begin
      rst = 0;
      idle(3);
      rst = 1;
      idle(2);
      test_reset();
      test_frame_4x2();
      test_min_count();
      test_abort();
      test_shadow_bubbles();
      test_single();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
